// File: rtl/dlfloat_to_fp32_decoder.sv
// DLFloat16 (1|6 bias 31|9) to IEEE-754 fp32 streaming decoder.
// Two-stage valid/ready pipeline with saturating per-class delivery counters.
module dlfloat_to_fp32_decoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NAN_FP32 = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_class,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_nan
);

  localparam logic [1:0]       CLS_NORM = 2'b00;
  localparam logic [1:0]       CLS_ZERO = 2'b01;
  localparam logic [1:0]       CLS_SUB  = 2'b10;
  localparam logic [1:0]       CLS_NAN  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        s1_valid;
  logic [15:0] s1_data;
  logic [1:0]  s1_class;
  logic        s2_valid;
  logic [31:0] s2_data;
  logic [1:0]  s2_class;
  logic        s1_adv;
  logic        s2_adv;
  logic        xfer;
  logic [1:0]  in_class;
  logic [31:0] s1_fp32;

  // Handshake: a word moves on any edge where valid & ready are both high;
  // a stage may load when it is empty or its contents move on the same edge.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv || rst;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_class = s2_class;
  assign xfer      = s2_valid && out_ready;

  always_comb begin
    in_class = CLS_NORM;
    if (in_data[14:9] == 6'd63)
      in_class = CLS_NAN;
    else if (in_data[14:9] == 6'd0)
      in_class = (in_data[8:0] == 9'd0) ? CLS_ZERO : CLS_SUB;
  end

  // Rebias 31 -> 127; the 9-bit fraction maps exactly onto the top of fp32's 23.
  always_comb begin
    s1_fp32 = {s1_data[15], 31'b0};
    case (s1_class)
      CLS_NORM: s1_fp32 = {s1_data[15], {2'b00, s1_data[14:9]} + 8'd96, s1_data[8:0], 14'b0};
      CLS_NAN:  s1_fp32 = NAN_FP32;
      default:  s1_fp32 = {s1_data[15], 31'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= 16'd0;
      s1_class <= CLS_NORM;
      s2_valid <= 1'b0;
      s2_data  <= 32'd0;
      s2_class <= CLS_NORM;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_class <= in_class;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= s1_fp32;
          s2_class <= s1_class;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_zero <= '0;
      cnt_sub  <= '0;
      cnt_nan  <= '0;
    end else if (xfer) begin
      case (s2_class)
        CLS_ZERO: if (cnt_zero != CNT_MAX) cnt_zero <= cnt_zero + CNT_ONE;
        CLS_SUB:  if (cnt_sub != CNT_MAX) cnt_sub <= cnt_sub + CNT_ONE;
        CLS_NAN:  if (cnt_nan != CNT_MAX) cnt_nan <= cnt_nan + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_to_fp32_decoder.sv
// Scoreboard bench for dlfloat_to_fp32_decoder: driver pushes expected words,
// an independent monitor pops and compares on every output transfer.
module tb_dlfloat_to_fp32_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_class;
  logic        clr_cnt;
  logic [15:0] cnt_zero, cnt_sub, cnt_nan;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] in_data2;
  logic [31:0] out_data2;
  logic [1:0]  out_class2;
  logic [1:0]  cnt_zero2, cnt_sub2, cnt_nan2;

  always #5 clk = ~clk;

  dlfloat_to_fp32_decoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .clr_cnt(clr_cnt), .cnt_zero(cnt_zero), .cnt_sub(cnt_sub), .cnt_nan(cnt_nan)
  );

  dlfloat_to_fp32_decoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_class(out_class2),
    .clr_cnt(1'b0), .cnt_zero(cnt_zero2), .cnt_sub(cnt_sub2), .cnt_nan(cnt_nan2)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [33:0] exp_q[$];
  int          lat_q[$];
  bit          lat_en   = 1'b0;
  bit          rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [33:0] ref_decode(input logic [15:0] w);
    logic [5:0] e;
    logic [7:0] be;
    e = w[14:9];
    if (e == 6'd63) return {2'd3, 32'h7FC00000};
    if (e == 6'd0) return {(w[8:0] == 9'd0) ? 2'd1 : 2'd2, w[15], 31'b0};
    be = 8'(int'(e) + 96);
    return {2'd0, w[15], be, w[8:0], 14'b0};
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [15:0] w, input logic [33:0] e);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 500 && !acc; t++) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(e);
        lat_q.push_back(cyc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: word %h not accepted within 500 cycles", w);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples mid-low-phase, i.e. the values the next rising edge will see.
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;
  always @(negedge clk) begin
    logic [33:0] e;
    int          l;
    #2;
    if (prev_stall) check("stall_hold", {5'd0, out_valid, out_class, out_data}, {5'd0, prev_out});
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got %h/%0d, required no output", out_data, out_class);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("out_word", {6'd0, out_class, out_data}, {6'd0, e});
        if (lat_en) check("latency", 40'(cyc - l), 40'd2);
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_out   = {out_valid, out_class, out_data};
  end

  logic [15:0] bp_w[8] = '{16'h3EA3, 16'h4073, 16'hC073, 16'h0000,
                           16'h8000, 16'h01AC, 16'hFFFF, 16'h7DFE};
  logic [33:0] bp_e[8] = '{{2'd0, 32'h3FA8C000}, {2'd0, 32'h401CC000}, {2'd0, 32'hC01CC000},
                           {2'd1, 32'h00000000}, {2'd1, 32'h80000000}, {2'd2, 32'h00000000},
                           {2'd3, 32'h7FC00000}, {2'd0, 32'h4F7F8000}};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  40'(in_ready), 40'd1);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_out",       {6'd0, out_class, out_data}, 40'd0);
    check("rst_cnts",      {cnt_zero, cnt_sub, cnt_nan[7:0]}, 40'd0);
    rst = 1'b0;
    @(negedge clk);

    // streaming and specials, one word per cycle, 2-cycle latency
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) send(bp_w[i], bp_e[i]);
    drain();
    send(16'h0000, {2'd1, 32'h00000000});
    send(16'h8000, {2'd1, 32'h80000000});
    send(16'h01AC, {2'd2, 32'h00000000});
    send(16'hFFFF, {2'd3, 32'h7FC00000});
    send(16'h7E01, {2'd3, 32'h7FC00000});
    send(16'h7DFE, {2'd0, 32'h4F7F8000});
    drain();
    lat_en = 1'b0;

    // class counters
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    send(16'h0000, {2'd1, 32'h00000000});
    send(16'h8000, {2'd1, 32'h80000000});
    send(16'h0000, {2'd1, 32'h00000000});
    send(16'h0001, {2'd2, 32'h00000000});
    send(16'h81FF, {2'd2, 32'h80000000});
    send(16'h7E00, {2'd3, 32'h7FC00000});
    drain();
    check("cnt_zero", 40'(cnt_zero), 40'd3);
    check("cnt_sub",  40'(cnt_sub),  40'd2);
    check("cnt_nan",  40'(cnt_nan),  40'd1);

    // reset with both stages full
    out_ready = 1'b0;
    send(16'h3EA3, {2'd0, 32'h3FA8C000});
    send(16'h4073, {2'd0, 32'h401CC000});
    check("full_in_ready", 40'(in_ready), 40'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 40'(in_ready), 40'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("rst_mid_out_valid", 40'(out_valid), 40'd0);
    check("rst_mid_in_ready2", 40'(in_ready), 40'd1);
    check("rst_mid_cnts", {cnt_zero, cnt_sub, cnt_nan[7:0]}, 40'd0);
    out_ready = 1'b1;
    send(16'h7DFE, {2'd0, 32'h4F7F8000});
    drain();

    // clear coincident with a NaN transfer
    out_ready = 1'b0;
    send(16'hFFFF, {2'd3, 32'h7FC00000});
    @(negedge clk);
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_vs_nan", 40'(cnt_nan), 40'd0);
    drain();

    // backpressure: out_ready low for cycles 3..6 of an 8-word stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_w[i], bp_e[i]);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          if (c >= 3 && c <= 6) begin
            #1;
            check("bp_in_ready", 40'(in_ready), 40'd0);
          end
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // random traffic against the reference decode
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          w = 16'($urandom);
          send(w, ref_decode(w));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // saturation with CNT_W=2
    in_valid2 = 1'b1;
    in_data2  = 16'hFFFF;
    repeat (5) @(negedge clk);
    in_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_cnt_nan",  40'(cnt_nan2), 40'd3);
    check("sat_cnt_zero", 40'(cnt_zero2), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
